bcd_to_binary_seq: RTL
======================

Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter; inverse of the team's combinational binary_to_bcd.
- Accepts a packed DIGITS-digit BCD word on a start pulse and runs reverse double-dabble: one shift-right plus per-digit correction per clock.
- Returns the binary value with a one-cycle done pulse.
- Sits on the input side of the display/keypad datapath, turning BCD user entry back into binary for arithmetic blocks.

Parameters:
- DIGITS, 2, number of BCD digits in bcd_in (4 bits each, digit 0 in bits [3:0]).
- BIN_W, 7, binary result width; must satisfy 2^BIN_W > 10^DIGITS - 1. Also the number of conversion cycles.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  BCD operand; sampled on the accepting edge only.
- busy  output  1  high in CONV.
- done  output  1  one-cycle pulse when bin_out and err are valid.
- bin_out  output  BIN_W  result; held from done until the next done.
- err  output  1  invalid-digit flag; valid with done, held like bin_out.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, busy=0, done=0, bin_out=0, err=0, internal shift/count registers cleared.
- States: IDLE, CONV, DONE.
- IDLE, start=1 at edge E0:
  - If any nibble of bcd_in > 9 and BCD2BIN_CHECK_EN is defined: go to DONE, err=1, bin_out=0. Latency 1 cycle.
  - Otherwise: load shift register {bcd_in, BIN_W'b0}, count=0, go to CONV, busy=1.
- CONV, one step per edge:
  - Shift the whole {bcd, bin} register right by 1; the bcd LSB enters the bin MSB.
  - Then for each digit of the shifted bcd field: if the digit >= 8, subtract 3 (4-bit, no carry between digits).
  - count increments each step. After step BIN_W, at edge E(BIN_W): bin_out = bin field, err=0, done=1, busy=0, go to DONE.
  - Total latency from the accepting edge E0 to the done cycle: BIN_W cycles.
- DONE: lasts exactly one cycle with done=1; returns to IDLE. start during DONE is ignored. Back-to-back throughput: one conversion per BIN_W+2 cycles.
- start during CONV or DONE is ignored. bcd_in changes after E0 have no effect.
- bin_out and err change only on the done edge or on reset.
- Reset mid-CONV: immediate abort, all outputs to reset values, no done pulse.
- Boundary values: all-zero input gives bin_out=0. All-nines input gives 10^DIGITS - 1. The bcd field is zero after the final step for every valid input.

Optional Feature:
- Macro BCD2BIN_CHECK_EN.
- Defined: nibble validity check as described. Invalid input produces done one cycle after E0 with err=1 and bin_out=0; no conversion cycles are spent.
- Not defined: err is tied to 0. Every input goes through CONV with BIN_W-cycle latency. bin_out for invalid nibbles is deterministic but unspecified, and the bench does not check it.

Test Plan (DIGITS=2, BIN_W=7):
- Round trip: for i = 0..31, drive bcd_in = {i/10, i%10} with one start each -> bin_out == i, err=0, done exactly 7 cycles after the accepting edge, busy high for those 7 cycles.
- Extremes: bcd_in = 8'h00 -> bin_out = 0; bcd_in = 8'h99 -> bin_out = 7'd99; bcd_in = 8'h64 -> bin_out = 7'd64.
- Invalid digit (CHECK_EN defined): bcd_in = 8'h3A -> done on the next cycle, err=1, bin_out=0. A subsequent 8'h12 -> bin_out = 12, err cleared to 0.
- Busy protection: start with 8'h45, then pulse start with 8'h77 during CONV and again in the DONE cycle -> a single done with bin_out = 45; bin_out stays 45 until a new accepted start completes.
- Reset mid-operation: start with 8'h58, assert rst_n=0 after 3 cycles -> busy, done, bin_out, err go to 0 immediately with no done pulse. After release, start with 8'h07 -> bin_out = 7 after 7 cycles.

Source files
------------

// File: rtl/bcd_to_binary_seq_if.sv
// bcd_to_binary_seq_if: start/operand request and result/status bundle for bcd_to_binary_seq.
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) ();
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (output start, bcd_in, input busy, done, bin_out, err);
    modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential reverse double-dabble BCD-to-binary converter.
// Define BCD2BIN_CHECK_EN to reject operands with any nibble above 9 (err=1, bin_out=0).
module bcd_to_binary_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic clk,
    input  logic rst_n,
    bcd_to_binary_seq_if.slave io
);
    localparam int W  = 4*DIGITS + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state, state_nx;
    logic [W-1:0]     sr, sr_nx, sh;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [BIN_W-1:0] bin, bin_nx;
    logic             err, err_nx;
    logic             bad;

`ifdef BCD2BIN_CHECK_EN
    logic [DIGITS-1:0] nib_bad;
    for (genvar d = 0; d < DIGITS; d++) begin : g_chk
        assign nib_bad[d] = io.bcd_in[4*d +: 4] > 4'd9;
    end
    assign bad = |nib_bad;
`else
    assign bad = 1'b0;
`endif

    // one step: shift right, then pull each BCD digit that reached 8+ back down by 3
    always_comb begin
        sh = sr >> 1;
        for (int i = 0; i < DIGITS; i++)
            if (sh[BIN_W+4*i +: 4] >= 4'd8) sh[BIN_W+4*i +: 4] = sh[BIN_W+4*i +: 4] - 4'd3;
    end

    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        bin_nx   = bin;
        err_nx   = err;
        case (state)
            IDLE: if (io.start) begin
                if (bad) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                    bin_nx   = '0;
                end else begin
                    state_nx = CONV;
                    sr_nx    = {io.bcd_in, {BIN_W{1'b0}}};
                    cnt_nx   = '0;
                end
            end
            CONV: begin
                sr_nx  = sh;
                cnt_nx = cnt + 1'b1;
                if (cnt == CW'(BIN_W - 1)) begin
                    state_nx = DONE;
                    bin_nx   = sh[BIN_W-1:0];
                    err_nx   = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            bin   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            cnt   <= cnt_nx;
            bin   <= bin_nx;
            err   <= err_nx;
        end
    end

    assign io.busy    = state == CONV;
    assign io.done    = state == DONE;
    assign io.bin_out = bin;
    assign io.err     = err;
endmodule
